// File: rtl/reg_dump_pkg.sv
// Shared widths and FSM state encoding for the register dump engine.
package reg_dump_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        HOLD   = 2'd2,
        FINISH = 2'd3
    } dumpState_t;

endpackage

// File: rtl/reg_dump.sv
// Register dump engine: walks a register-file address range (wrapping at the
// top) and presents each word on a valid/ready output with a last flag.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [ADDR_W-1:0] FirstAddr,
    input  logic [ADDR_W-1:0] LastAddr,
    output logic [ADDR_W-1:0] RdAddr,
    input  logic [DATA_W-1:0] RdData,
    output logic [DATA_W-1:0] OutData,
    output logic [ADDR_W-1:0] OutAddr,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              OutLast,
    output logic              Busy,
    output logic              Done
);

    dumpState_t        state;
    dumpState_t        nextState;
    logic [ADDR_W-1:0] addrCnt;
    logic [ADDR_W-1:0] endAddr;
    logic              handshake;

    // The read port always tracks the counter so it never points elsewhere.
    assign RdAddr    = addrCnt;
    assign handshake = OutValid && OutReady;

    // State register; reset overrides any pending Start.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and state-decoded status outputs.
    always_comb begin
        nextState = state;
        OutValid  = 1'b0;
        Busy      = 1'b1;
        Done      = 1'b0;
        unique case (state)
            IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    nextState = READ;
                end
            end
            READ: begin
                nextState = HOLD;
            end
            HOLD: begin
                OutValid = 1'b1;
                if (handshake) begin
                    nextState = OutLast ? FINISH : READ;
                end
            end
            FINISH: begin
                Done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Address counter, range end and captured output word.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            addrCnt <= '0;
            endAddr <= '0;
            OutData <= '0;
            OutAddr <= '0;
            OutLast <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        addrCnt <= FirstAddr;
                        endAddr <= LastAddr;
                    end
                end
                READ: begin
                    OutData <= RdData;
                    OutAddr <= addrCnt;
                    OutLast <= (addrCnt == endAddr);
                end
                HOLD: begin
                    if (handshake && !OutLast) begin
                        addrCnt <= addrCnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
